// File: rtl/jt49_pkg.sv
// Shared constants for the jt49 divider bank.
// Also holds the value a channel count reloads to after a toggle.
package jt49_pkg;

    localparam int JT49_NCH    = 4;
    localparam int JT49_SLOT_W = 2;
    localparam int JT49_PER_W  = 12;

    // Counts start at one, so period 0 and period 1 both toggle on every service.
    localparam int JT49_COUNT_ONE = 1;

endpackage

// File: rtl/jt49_div_step.sv
// Compare/reload/increment rule for one divider service.
// Kept separate so a future single-channel divider uses the same rule.
module jt49_div_step
    import jt49_pkg::*;
#(
    parameter int W = JT49_PER_W
) (
    input  logic [W-1:0] count,
    input  logic [W-1:0] period,
    output logic [W-1:0] count_nxt,
    output logic         toggle
);

    always_comb begin
        toggle    = (count >= period);
        count_nxt = toggle ? W'(JT49_COUNT_ONE) : count + W'(1);
    end

endmodule

// File: rtl/jt49_div_sched.sv
// Time-multiplexed tone/noise divider bank: one shared compare/increment
// datapath walks the channels, one channel per cen pulse.
module jt49_div_sched
    import jt49_pkg::*;
#(
    parameter int W  = JT49_PER_W,
    parameter int N  = JT49_NCH,
    parameter int AW = JT49_SLOT_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cen,
    input  logic          wr,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic          restart,
    output logic [N-1:0]  div,
    output logic [N-1:0]  tick,
    output logic [AW-1:0] slot
);

    logic [W-1:0]  count_q  [N];
    logic [W-1:0]  count_d  [N];
    logic [W-1:0]  period_q [N];
    logic [W-1:0]  period_d [N];
    logic [N-1:0]  div_q, div_d;
    logic [N-1:0]  tick_q, tick_d;
    logic [AW-1:0] slot_q, slot_d;

    logic [W-1:0]  svc_count;
    logic [W-1:0]  svc_period;
    logic [W-1:0]  svc_count_nxt;
    logic          svc_toggle;

    assign svc_count  = count_q[slot_q];
    assign svc_period = period_q[slot_q];

    jt49_div_step #(.W(W)) u_step (
        .count     (svc_count),
        .period    (svc_period),
        .count_nxt (svc_count_nxt),
        .toggle    (svc_toggle)
    );

    always_comb begin
        count_d  = count_q;
        period_d = period_q;
        div_d    = div_q;
        tick_d   = '0;
        slot_d   = slot_q;

        if (cen) begin
            count_d[slot_q] = svc_count_nxt;
            if (svc_toggle) begin
                div_d[slot_q]  = ~div_q[slot_q];
                tick_d[slot_q] = 1'b1;
            end
            slot_d = slot_q + AW'(1);
        end

        // The service above already used the old period; a restart on the
        // same channel discards its result, including the tick.
        if (wr) begin
            period_d[wr_addr] = wr_data;
            if (restart) begin
                count_d[wr_addr] = W'(JT49_COUNT_ONE);
                div_d[wr_addr]   = 1'b0;
                tick_d[wr_addr]  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                count_q[i]  <= W'(JT49_COUNT_ONE);
                period_q[i] <= '0;
            end
            div_q  <= '0;
            tick_q <= '0;
            slot_q <= '0;
        end else begin
            count_q  <= count_d;
            period_q <= period_d;
            div_q    <= div_d;
            tick_q   <= tick_d;
            slot_q   <= slot_d;
        end
    end

    assign div  = div_q;
    assign tick = tick_q;
    assign slot = slot_q;

endmodule

// File: tb/tb_jt49_div_sched.sv
// Self-checking bench for jt49_div_sched against a behavioural channel model.
module tb_jt49_div_sched;

    localparam int W  = 12;
    localparam int N  = 4;
    localparam int AW = 2;

    logic          clk;
    logic          rst_n;
    logic          cen;
    logic          wr;
    logic [AW-1:0] wr_addr;
    logic [W-1:0]  wr_data;
    logic          restart;
    logic [N-1:0]  div;
    logic [N-1:0]  tick;
    logic [AW-1:0] slot;

    int errors;
    int checks;

    // reference model state
    int           m_cnt [N];
    int           m_per [N];
    logic [N-1:0] m_div;
    logic [N-1:0] m_tick;
    int           m_slot;

    jt49_div_sched #(.W(W), .N(N), .AW(AW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .cen     (cen),
        .wr      (wr),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .restart (restart),
        .div     (div),
        .tick    (tick),
        .slot    (slot)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_cnt[i] = 1;
            m_per[i] = 0;
        end
        m_div  = '0;
        m_tick = '0;
        m_slot = 0;
    endtask

    // driver: apply one clk cycle of inputs and advance the model by the rules
    task automatic cyc(input logic c, input logic w, input int a, input int d, input logic r);
        logic [N-1:0] nt;
        int k;
        cen = c; wr = w; wr_addr = AW'(a); wr_data = W'(d); restart = r;
        @(posedge clk);
        nt = '0;
        if (c) begin
            k = m_slot;
            if (m_cnt[k] >= m_per[k]) begin
                m_cnt[k] = 1;
                m_div[k] = ~m_div[k];
                nt[k] = 1'b1;
            end else begin
                m_cnt[k] = m_cnt[k] + 1;
            end
            m_slot = (m_slot + 1) % N;
        end
        if (w) begin
            m_per[a] = d;
            if (r) begin
                m_cnt[a] = 1;
                m_div[a] = 1'b0;
                nt[a] = 1'b0;
            end
        end
        m_tick = nt;
        #1;
        cen = 1'b0; wr = 1'b0; restart = 1'b0;
    endtask

    task automatic test_reset();
        cen = 0; wr = 0; wr_addr = '0; wr_data = '0; restart = 0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (div !== 4'b0)  begin errors++; $display("FAIL reset_div got=%b exp=0000", div); end
        checks++; if (tick !== 4'b0) begin errors++; $display("FAIL reset_tick got=%b exp=0000", tick); end
        checks++; if (slot !== 2'd0) begin errors++; $display("FAIL reset_slot got=%0d exp=0", slot); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_period_zero();
        for (int i = 0; i < 16; i++) begin
            cyc(1, 0, 0, 0, 0);
            checks++; if (slot !== AW'((i + 1) % N)) begin errors++; $display("FAIL p0_slot i=%0d got=%0d exp=%0d", i, slot, (i + 1) % N); end
            checks++; if (div !== m_div) begin errors++; $display("FAIL p0_div i=%0d got=%b exp=%b", i, div, m_div); end
            checks++; if (tick !== (4'b1 << (i % N))) begin errors++; $display("FAIL p0_tick i=%0d got=%b exp=%b", i, tick, 4'b1 << (i % N)); end
        end
    endtask

    task automatic test_period_three();
        logic [N-1:0] prev;
        int last;
        int ncen;
        cyc(0, 1, 0, 3, 0);
        for (int a = 1; a < N; a++) cyc(0, 1, a, 12'hFFF, 0);
        prev = div; last = -1; ncen = 0;
        for (int i = 0; i < 80; i++) begin
            cyc(1, 0, 0, 0, 0);
            ncen++;
            checks++; if (div !== m_div || tick !== m_tick) begin errors++; $display("FAIL p3_state i=%0d div=%b/%b tick=%b/%b", i, div, m_div, tick, m_tick); end
            if (div[0] !== prev[0]) begin
                if (last >= 0) begin
                    checks++; if (ncen - last != 12) begin errors++; $display("FAIL p3_interval got=%0d exp=12", ncen - last); end
                end
                last = ncen;
            end
            checks++; if (div[3:1] !== prev[3:1]) begin errors++; $display("FAIL p3_static got=%b exp=%b", div[3:1], prev[3:1]); end
            prev = div;
        end
    endtask

    task automatic test_cen_gap();
        logic [N-1:0] prev;
        logic [AW-1:0] pslot;
        int last;
        int ncen;
        cyc(0, 1, 2, 2, 1);
        prev = div; pslot = slot; last = -1; ncen = 0;
        for (int i = 0; i < 120; i++) begin
            cyc((i % 3) == 0, 0, 0, 0, 0);
            checks++; if (div !== m_div || tick !== m_tick || slot !== AW'(m_slot)) begin errors++; $display("FAIL gap_state i=%0d div=%b/%b tick=%b/%b slot=%0d/%0d", i, div, m_div, tick, m_tick, slot, m_slot); end
            if ((i % 3) != 0) begin
                checks++; if (div !== prev || slot !== pslot || tick !== 4'b0) begin errors++; $display("FAIL gap_hold i=%0d div=%b/%b slot=%0d/%0d", i, div, prev, slot, pslot); end
            end else begin
                ncen++;
                if (div[2] !== prev[2]) begin
                    if (last >= 0) begin
                        checks++; if (ncen - last != 8) begin errors++; $display("FAIL gap_interval got=%0d exp=8", ncen - last); end
                    end
                    last = ncen;
                end
            end
            prev = div; pslot = slot;
        end
    endtask

    task automatic test_period_shrink();
        int guard;
        cyc(0, 1, 1, 10, 1);
        // walk until channel 1 has reached count 7
        guard = 0;
        while (m_cnt[1] != 7 && guard < 200) begin
            cyc(1, 0, 0, 0, 0);
            guard++;
        end
        checks++; if (guard >= 200) begin errors++; $display("FAIL shrink_setup got=timeout exp=count7"); end
        checks++; if (div[1] !== 1'b0) begin errors++; $display("FAIL shrink_pre_div got=%b exp=0", div[1]); end
        cyc(0, 1, 1, 4, 0);
        guard = 0;
        while (m_slot != 1 && guard < N) begin
            cyc(1, 0, 0, 0, 0);
            guard++;
        end
        cyc(1, 0, 0, 0, 0);
        checks++; if (div[1] !== 1'b1) begin errors++; $display("FAIL shrink_toggle got=%b exp=1", div[1]); end
        checks++; if (tick !== 4'b0010) begin errors++; $display("FAIL shrink_tick got=%b exp=0010", tick); end
        for (int i = 0; i < 40; i++) begin
            cyc(1, 0, 0, 0, 0);
            checks++; if (div !== m_div || tick !== m_tick) begin errors++; $display("FAIL shrink_state i=%0d div=%b/%b tick=%b/%b", i, div, m_div, tick, m_tick); end
        end
    endtask

    task automatic test_restart_collide();
        int guard;
        cyc(0, 1, 3, 1, 0);
        guard = 0;
        while ((m_slot != 3 || m_div[3] != 1'b1) && guard < 40) begin
            cyc(1, 0, 0, 0, 0);
            guard++;
        end
        checks++; if (guard >= 40) begin errors++; $display("FAIL collide_setup got=timeout exp=slot3"); end
        cyc(1, 1, 3, 2, 1);
        checks++; if (div[3] !== 1'b0)  begin errors++; $display("FAIL collide_div got=%b exp=0", div[3]); end
        checks++; if (tick[3] !== 1'b0) begin errors++; $display("FAIL collide_tick got=%b exp=0", tick[3]); end
        checks++; if (slot !== 2'd0)    begin errors++; $display("FAIL collide_slot got=%0d exp=0", slot); end
        // period 2 from count 1: the next service of 3 must not toggle, the one after must
        for (int i = 0; i < 8; i++) begin
            cyc(1, 0, 0, 0, 0);
            checks++; if (div !== m_div || tick !== m_tick) begin errors++; $display("FAIL collide_after i=%0d div=%b/%b tick=%b/%b", i, div, m_div, tick, m_tick); end
        end
        checks++; if (div[3] !== 1'b1) begin errors++; $display("FAIL collide_newper got=%b exp=1", div[3]); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, $urandom_range(0, N - 1),
                $urandom_range(0, 6), $urandom_range(0, 2) == 0);
            checks++; if (div !== m_div || tick !== m_tick || slot !== AW'(m_slot)) begin errors++; $display("FAIL rand_state i=%0d div=%b/%b tick=%b/%b slot=%0d/%0d", i, div, m_div, tick, m_tick, slot, m_slot); end
            checks++; if ($countones(tick) > 1) begin errors++; $display("FAIL rand_onehot got=%b exp=at_most_one", tick); end
        end
    endtask

    task automatic test_reset_mid();
        int guard;
        for (int a = 0; a < N; a++) cyc(0, 1, a, 0, 1);
        cyc(0, 1, 1, 1, 0);
        cyc(0, 1, 3, 1, 0);
        cyc(0, 1, 0, 12'hFFF, 0);
        cyc(0, 1, 2, 12'hFFF, 0);
        guard = 0;
        while (m_div != 4'b1010 && guard < 8) begin
            cyc(1, 0, 0, 0, 0);
            guard++;
        end
        checks++; if (div !== 4'b1010) begin errors++; $display("FAIL mid_setup got=%b exp=1010", div); end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if (div !== 4'b0 || tick !== 4'b0 || slot !== 2'd0) begin errors++; $display("FAIL mid_async div=%b tick=%b slot=%0d exp=0", div, tick, slot); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        cyc(1, 0, 0, 0, 0);
        checks++; if (slot !== 2'd1)     begin errors++; $display("FAIL mid_first_slot got=%0d exp=1", slot); end
        checks++; if (tick !== 4'b0001)  begin errors++; $display("FAIL mid_first_tick got=%b exp=0001", tick); end
        checks++; if (div !== 4'b0001)   begin errors++; $display("FAIL mid_first_div got=%b exp=0001", div); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_period_zero();
        test_period_three();
        test_cen_gap();
        test_period_shrink();
        test_restart_collide();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
